// File: rtl/key_entry_buffer.sv
// Keypad entry front-end: debounces scanned keys, builds a BCD operand from
// digits, and hands operator keys to the arithmetic core over valid/ack.
module key_entry_buffer #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         KeyRead,
  input  logic [3:0]                   BCDKey,
  output logic [4*DIGITS-1:0]          operand,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic [2:0]                   op_code,
  output logic                         op_valid,
  input  logic                         op_ack,
  output logic                         clear_pulse,
  output logic                         overflow
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam int DCW = $clog2(DIGITS + 1);

  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [DCW-1:0] DIG_FULL = DCW'(DIGITS);
  localparam logic [DCW-1:0] DIG_ONE  = DCW'(1);
  localparam logic [3:0]     KEY_CLR  = 4'd14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           key_q, key_d;
  logic [4*DIGITS-1:0]  operand_q, operand_d;
  logic [DCW-1:0]       count_q, count_d;
  logic [2:0]           op_code_q, op_code_d;
  logic                 op_valid_q, op_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 clear_q, clear_d;

  // Debounce sequencing plus the key action taken in the single ACCEPT cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    operand_d  = operand_q;
    count_d    = count_q;
    op_code_d  = op_code_q;
    op_valid_d = op_valid_q;
    overflow_d = overflow_q;
    clear_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (KeyRead) begin
          key_d   = BCDKey;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else begin
          state_d = IDLE;
        end
      end
      DEBOUNCE: begin
        if (!KeyRead) begin
          state_d = IDLE;
        end else if (BCDKey != key_q) begin
          key_d = BCDKey;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ACCEPT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ACCEPT: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        // Any re-assertion of KeyRead restarts the release window.
        if (KeyRead) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (op_valid_q && op_ack) begin
      op_valid_d = 1'b0;
      operand_d  = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      op_valid_d = op_valid_d;
    end

    if (state_q == ACCEPT) begin
      if (key_q == KEY_CLR) begin
        op_valid_d = 1'b0;
        operand_d  = '0;
        count_d    = '0;
        overflow_d = 1'b0;
        clear_d    = 1'b1;
      end else if (op_valid_q) begin
        op_valid_d = op_valid_d;
      end else if (key_q <= 4'd9) begin
        if ((count_q == '0) && (key_q == 4'd0)) begin
          operand_d = operand_q;
        end else if (count_q < DIG_FULL) begin
          operand_d = {operand_q[4*DIGITS-5:0], key_q};
          count_d   = count_q + DIG_ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        op_code_d  = 3'(key_q - 4'd10);
        op_valid_d = 1'b1;
      end
    end else begin
      clear_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= 4'd0;
      operand_q  <= '0;
      count_q    <= '0;
      op_code_q  <= 3'd0;
      op_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      operand_q  <= operand_d;
      count_q    <= count_d;
      op_code_q  <= op_code_d;
      op_valid_q <= op_valid_d;
      overflow_q <= overflow_d;
      clear_q    <= clear_d;
    end
  end

  assign operand     = operand_q;
  assign digit_count = count_q;
  assign op_code     = op_code_q;
  assign op_valid    = op_valid_q;
  assign clear_pulse = clear_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: table of clean key presses, hand-written corner
// sequences, then random stimulus, all checked against a run-length key model.
module tb_key_entry_buffer;
  localparam int D   = 4;
  localparam int N   = 4;
  localparam int DCW = $clog2(N + 1);

  localparam int PH_ARMED = 0;
  localparam int PH_ACT   = 1;
  localparam int PH_REL   = 2;

  logic            clk = 1'b0;
  logic            rst, kr, ack;
  logic [3:0]      key;
  logic [4*N-1:0]  operand;
  logic [DCW-1:0]  dcount;
  logic [2:0]      code;
  logic            valid, clrp, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  int         m_phase, m_run, m_zrun, m_val, m_cnt, m_code;
  logic [3:0] m_key;
  bit         m_valid, m_ovf, m_clr;

  typedef struct {
    int         key;
    bit         ack_only;
    int         idle;
    logic [15:0] e_op;
    int         e_cnt;
    bit         e_valid;
    int         e_code;
    bit         e_ovf;
  } vec_t;
  vec_t tbl[16];

  int         rk, rh, rg;
  logic [3:0] kk;

  always #5 clk = ~clk;

  key_entry_buffer #(.DIGITS(N), .DEBOUNCE_CYCLES(D)) dut (
    .CLK(clk), .RESET(rst), .KeyRead(kr), .BCDKey(key),
    .operand(operand), .digit_count(dcount), .op_code(code),
    .op_valid(valid), .op_ack(ack), .clear_pulse(clrp), .overflow(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = 16'h0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] pack(input logic [15:0] op, input int cnt, input int cd,
                                       input bit v, input bit c, input bit o);
    return {7'd0, o, c, v, 3'(cd), 3'(cnt), op};
  endfunction

  task automatic model_clear();
    m_val = 0; m_cnt = 0; m_valid = 1'b0; m_ovf = 1'b0;
  endtask

  // One clock edge of the reference: a key is taken once D+1 identical held
  // samples are seen while armed; re-armed after D consecutive released samples.
  task automatic model_edge(input bit k_r, input logic [3:0] k, input bit a, input bit r);
    bit pv;
    if (r) begin
      m_phase = PH_ARMED; m_run = 0; m_zrun = 0; m_code = 0; m_clr = 1'b0;
      model_clear();
      return;
    end
    m_clr = 1'b0;
    pv = m_valid;
    if (pv && a) model_clear();
    if (m_phase == PH_ACT) begin
      if (m_key == 4'd14) begin
        model_clear();
        m_clr = 1'b1;
      end else if (!pv) begin
        if (m_key <= 4'd9) begin
          if (!(m_cnt == 0 && m_key == 4'd0)) begin
            if (m_cnt < N) begin
              m_val = m_val * 10 + int'(m_key);
              m_cnt++;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end else begin
          m_code  = int'(m_key) - 10;
          m_valid = 1'b1;
        end
      end
    end
    case (m_phase)
      PH_ARMED: begin
        if (k_r) begin
          if (m_run > 0 && k == m_key) m_run++;
          else begin m_run = 1; m_key = k; end
          if (m_run == D + 1) m_phase = PH_ACT;
        end else begin
          m_run = 0;
        end
      end
      PH_ACT: begin
        m_phase = PH_REL;
        m_zrun  = 0;
      end
      default: begin
        if (!k_r) begin
          m_zrun++;
          if (m_zrun == D) begin m_phase = PH_ARMED; m_run = 0; end
        end else begin
          m_zrun = 0;
        end
      end
    endcase
  endtask

  task automatic step(input bit k_r, input logic [3:0] k, input bit a, input bit r);
    @(negedge clk);
    kr = k_r; key = k; ack = a; rst = r;
    model_edge(k_r, k, a, r);
    @(posedge clk);
    #1;
    check("model", pack(operand, int'(dcount), int'(code), valid, clrp, ovf),
          pack(to_bcd(m_val), m_cnt, m_code, m_valid, m_clr, m_ovf));
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel);
    for (int i = 0; i < hold; i++) step(1'b1, k, 1'b0, 1'b0);
    for (int i = 0; i < rel; i++) step(1'b0, k, 1'b0, 1'b0);
  endtask

  task automatic set_row(input int i, input int k, input bit a, input int idl, input logic [15:0] op,
                         input int cnt, input bit v, input int cd, input bit o);
    tbl[i].key = k; tbl[i].ack_only = a; tbl[i].idle = idl; tbl[i].e_op = op;
    tbl[i].e_cnt = cnt; tbl[i].e_valid = v; tbl[i].e_code = cd; tbl[i].e_ovf = o;
  endtask

  initial begin
    rst = 1'b1; kr = 1'b0; ack = 1'b0; key = 4'd0;
    model_edge(1'b0, 4'd0, 1'b0, 1'b1);

    set_row(0,  0, 0, 0,  16'h0000, 0, 0, 0, 0);
    set_row(1,  1, 0, 0,  16'h0001, 1, 0, 0, 0);
    set_row(2,  2, 0, 0,  16'h0012, 2, 0, 0, 0);
    set_row(3,  3, 0, 0,  16'h0123, 3, 0, 0, 0);
    set_row(4,  4, 0, 0,  16'h1234, 4, 0, 0, 0);
    set_row(5,  5, 0, 0,  16'h1234, 4, 0, 0, 1);
    set_row(6,  10, 0, 0, 16'h1234, 4, 1, 0, 1);
    set_row(7,  9, 0, 50, 16'h1234, 4, 1, 0, 1);
    set_row(8,  12, 0, 0, 16'h1234, 4, 1, 0, 1);
    set_row(9,  0, 1, 0,  16'h0000, 0, 0, 0, 0);
    set_row(10, 4, 0, 0,  16'h0004, 1, 0, 0, 0);
    set_row(11, 2, 0, 0,  16'h0042, 2, 0, 0, 0);
    set_row(12, 13, 0, 0, 16'h0042, 2, 1, 3, 0);
    set_row(13, 0, 1, 0,  16'h0000, 0, 0, 3, 0);
    set_row(14, 15, 0, 0, 16'h0000, 0, 1, 5, 0);
    set_row(15, 14, 0, 0, 16'h0000, 0, 0, 5, 0);

    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("reset", pack(operand, int'(dcount), int'(code), valid, clrp, ovf), 32'h0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < tbl[i].idle; j++) step(1'b0, 4'd0, 1'b0, 1'b0);
      if (tbl[i].ack_only) step(1'b0, 4'd0, 1'b1, 1'b0);
      else press(4'(tbl[i].key), 8, 6);
      check("tbl_operand", operand, tbl[i].e_op);
      check("tbl_count", dcount, tbl[i].e_cnt);
      check("tbl_valid", valid, tbl[i].e_valid);
      check("tbl_code", code, tbl[i].e_code);
      check("tbl_overflow", ovf, tbl[i].e_ovf);
    end

    // Latency: the held digit lands on exactly the sixth edge, once only.
    step(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'd7, 1'b0, 1'b0);
      if (i == 4) check("lat_before", operand, 16'h0000);
      if (i == 5) check("lat_at", operand, 16'h0007);
    end
    press(4'd7, 0, 10);
    check("lat_operand", operand, 16'h0007);
    check("lat_count", dcount, 1);

    // Short glitch, then a key change mid-debounce restarting the count.
    step(1'b0, 4'd0, 1'b0, 1'b1);
    press(4'd3, 2, 5);
    check("glitch", pack(operand, int'(dcount), int'(code), valid, clrp, ovf), 32'h0);
    press(4'd3, 2, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'd8, 1'b0, 1'b0);
      if (i == 4) check("rekey_before", operand, 16'h0000);
      if (i == 5) check("rekey_at", operand, 16'h0008);
    end
    press(4'd8, 0, 6);
    check("rekey_count", dcount, 1);

    // CLR accepted on the same edge as op_ack.
    step(1'b0, 4'd0, 1'b0, 1'b1);
    press(4'd5, 8, 6);
    press(4'd10, 8, 6);
    check("pre_clr_valid", valid, 1);
    press(4'd14, 5, 0);
    step(1'b1, 4'd14, 1'b1, 1'b0);
    check("clr_pulse", clrp, 1);
    check("clr_state", {operand, 3'(dcount), valid, ovf}, 21'd0);
    step(1'b1, 4'd14, 1'b0, 1'b0);
    check("clr_pulse_end", clrp, 0);
    press(4'd14, 0, 6);

    // Reset mid-debounce loses the pending key.
    press(4'd6, 8, 6);
    check("pre_rst_operand", operand, 16'h0006);
    press(4'd9, 3, 0);
    step(1'b1, 4'd9, 1'b0, 1'b1);
    check("rst_mid", pack(operand, int'(dcount), int'(code), valid, clrp, ovf), 32'h0);
    press(4'd9, 3, 6);
    check("rst_lost", operand, 16'h0000);

    // Release bounce restarts the release window; re-hold is not a new press.
    step(1'b0, 4'd0, 1'b0, 1'b1);
    press(4'd1, 8, 2);
    press(4'd1, 1, 3);
    press(4'd2, 8, 6);
    check("bounce_operand", operand, 16'h0001);
    check("bounce_count", dcount, 1);

    for (int t = 0; t < 300; t++) begin
      rk = ($urandom_range(0, 9) < 6) ? $urandom_range(0, 9) : $urandom_range(10, 15);
      rh = $urandom_range(1, 10);
      rg = $urandom_range(0, 8);
      for (int i = 0; i < rh; i++) begin
        kk = 4'(rk);
        if ($urandom_range(0, 19) == 0) kk = 4'($urandom_range(0, 15));
        step(1'b1, kk, ($urandom_range(0, 5) == 0), ($urandom_range(0, 399) == 0));
      end
      for (int i = 0; i < rg; i++)
        step(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
